// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
// palette_pkg : shared RGB type, black constant and power-on palette.
// Rev 1.0
// ============================================================================
package palette_pkg;

    localparam int unsigned RGB_CH_W      = 8;
    localparam int unsigned DEFAULT_COUNT = 11;

    typedef struct packed {
        logic [RGB_CH_W-1:0] r;
        logic [RGB_CH_W-1:0] g;
        logic [RGB_CH_W-1:0] b;
    } rgb_t;

    localparam rgb_t BLACK = '0;

    localparam rgb_t DEFAULT_PALETTE [DEFAULT_COUNT] = '{
        24'hFF85ED, 24'h03FBFF, 24'h0004FF, 24'hFF9D00,
        24'hFCF003, 24'h02EB44, 24'hB402EB, 24'hDE0000,
        24'h181721, 24'h4A4861, 24'hFFFFFF
    };

    // Entries beyond the default table come up black.
    function automatic rgb_t default_entry(input int unsigned idx);
        rgb_t e;
        e = BLACK;
        for (int unsigned k = 0; k < DEFAULT_COUNT; k++) begin
            if (idx == k) begin
                e = DEFAULT_PALETTE[k];
            end
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_regfile.sv
`default_nettype none
// ============================================================================
// palette_regfile : palette storage, one write port, combinational lookup port.
// Optional registered readback port when PALETTE_READBACK_EN is defined.
// Rev 1.0
// ============================================================================
module palette_regfile
    import palette_pkg::*;
#(
    parameter int unsigned COLOR_W     = RGB_CH_W,
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [3*COLOR_W-1:0]   wdata_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [3*COLOR_W-1:0]   rdata_o
`ifdef PALETTE_READBACK_EN
    ,
    input  logic                   re_i,
    input  logic [ADDR_W-1:0]      rb_addr_i,
    output logic [3*COLOR_W-1:0]   rb_data_o
`endif
);

    localparam int unsigned DATA_W = 3 * COLOR_W;

    logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
    logic              w_wr_hit;

    assign w_wr_hit = we_i && (32'(waddr_i) < NUM_ENTRIES);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= DATA_W'(default_entry(i));
            end
        end else if (w_wr_hit) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not visible.
    assign rdata_o = (32'(raddr_i) < NUM_ENTRIES) ? mem_q[raddr_i] : '0;

`ifdef PALETTE_READBACK_EN
    logic [DATA_W-1:0] rb_data_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rb_data_q <= '0;
        end else if (re_i) begin
            rb_data_q <= (32'(rb_addr_i) < NUM_ENTRIES) ? mem_q[rb_addr_i] : '0;
        end
    end

    assign rb_data_o = rb_data_q;
`endif

endmodule
`default_nettype wire

// File: rtl/palette_mapper.sv
`default_nettype none
// ============================================================================
// palette_mapper : two-stage colour-index -> RGB lookup with valid/ready.
// Optional macro PALETTE_READBACK_EN adds pal_re / pal_rdata readback.
// Rev 1.0
// ============================================================================
module palette_mapper
    import palette_pkg::*;
#(
    parameter  int unsigned INDEX_W     = 8,
    parameter  int unsigned COLOR_W     = RGB_CH_W,
    parameter  int unsigned NUM_ENTRIES = 16,
    localparam int unsigned ADDR_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INDEX_W-1:0]     in_index,
    input  logic                   in_blank,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLOR_W-1:0]     out_r,
    output logic [COLOR_W-1:0]     out_g,
    output logic [COLOR_W-1:0]     out_b,
    input  logic                   pal_we,
    input  logic [ADDR_W-1:0]      pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_wdata
`ifdef PALETTE_READBACK_EN
    ,
    input  logic                   pal_re,
    output logic [3*COLOR_W-1:0]   pal_rdata
`endif
);

    localparam int unsigned DATA_W = 3 * COLOR_W;

    logic                w_advance;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_pal_rdata;

    logic                s1_valid_q, s1_valid_d;
    logic [INDEX_W-1:0]  s1_index_q, s1_index_d;
    logic                s1_blank_q, s1_blank_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   rgb_q, rgb_d;

    // Whole pipe moves as one; any stall at the output freezes both stages.
    assign w_advance  = !out_valid_q || out_ready;
    assign in_ready   = w_advance;
    assign w_in_range = 32'(s1_index_q) < NUM_ENTRIES;

    palette_regfile #(
        .COLOR_W     (COLOR_W),
        .NUM_ENTRIES (NUM_ENTRIES),
        .ADDR_W      (ADDR_W)
    ) u_regfile (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .we_i      (pal_we),
        .waddr_i   (pal_addr),
        .wdata_i   (pal_wdata),
        .raddr_i   (s1_index_q[ADDR_W-1:0]),
        .rdata_o   (w_pal_rdata)
`ifdef PALETTE_READBACK_EN
        ,
        .re_i      (pal_re),
        .rb_addr_i (pal_addr),
        .rb_data_o (pal_rdata)
`endif
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_index_d  = s1_index_q;
        s1_blank_d  = s1_blank_q;
        out_valid_d = out_valid_q;
        rgb_d       = rgb_q;
        if (w_advance) begin
            s1_valid_d  = in_valid;
            s1_index_d  = in_index;
            s1_blank_d  = in_blank;
            out_valid_d = s1_valid_q;
            rgb_d       = (s1_blank_q || !w_in_range) ? DATA_W'(BLACK) : w_pal_rdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_index_q  <= '0;
            s1_blank_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_index_q  <= s1_index_d;
            s1_blank_q  <= s1_blank_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign out_g     = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign out_b     = rgb_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_palette_mapper.sv
`default_nettype none
// ============================================================================
// tb_palette_mapper : scoreboard bench for palette_mapper (directed + random).
// Rev 1.0
// ============================================================================
module tb_palette_mapper;

    localparam int NE = 16;

    logic        Clk       = 1'b0;
    logic        Reset_n   = 1'b1;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_index  = '0;
    logic        in_blank  = 1'b0;
    logic        out_ready = 1'b1;
    logic        pal_we    = 1'b0;
    logic [3:0]  pal_addr  = '0;
    logic [23:0] pal_wdata = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_r, out_g, out_b;
`ifdef PALETTE_READBACK_EN
    logic        pal_re = 1'b0;
    logic [23:0] pal_rdata;
`endif

    palette_mapper dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_blank  (in_blank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata)
`ifdef PALETTE_READBACK_EN
        ,
        .pal_re    (pal_re),
        .pal_rdata (pal_rdata)
`endif
    );

    always #5 Clk = ~Clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [23:0] exp_q [$];
    logic [23:0] ref_pal [NE];
    bit          rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic void ref_reset();
        logic [23:0] defaults [11];
        defaults = '{24'hFF85ED, 24'h03FBFF, 24'h0004FF, 24'hFF9D00, 24'hFCF003, 24'h02EB44,
                     24'hB402EB, 24'hDE0000, 24'h181721, 24'h4A4861, 24'hFFFFFF};
        for (int i = 0; i < NE; i++) ref_pal[i] = (i < 11) ? defaults[i] : 24'h000000;
    endfunction

    function automatic logic [23:0] ref_lookup(input logic [7:0] idx, input logic blank);
        if (blank) return 24'h000000;
        if (int'(idx) >= NE) return 24'h000000;
        return ref_pal[int'(idx)];
    endfunction

    // Monitor: a transfer completes at the posedge following this negedge.
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pixel: got %h expected no output", {out_r, out_g, out_b});
                end else begin
                    check("pixel", {8'h00, out_r, out_g, out_b}, {8'h00, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rand_ready_en) out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] idx, input logic blank);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_index = idx;
        in_blank = blank;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge Clk);
            if (in_ready) begin
                exp_q.push_back(ref_lookup(idx, blank));
                done = 1'b1;
            end
            @(posedge Clk);
            #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
    endtask

    task automatic pal_write(input logic [3:0] addr, input logic [23:0] data);
        pal_we    = 1'b1;
        pal_addr  = addr;
        pal_wdata = data;
        tick();
        pal_we    = 1'b0;
        ref_pal[int'(addr)] = data;
    endtask

    task automatic drain();
        int waited;
        rand_ready_en = 1'b0;
        out_ready     = 1'b1;
        in_valid      = 1'b0;
        waited        = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            tick();
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d pixels outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        ref_reset();
        #1 Reset_n = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_rgb", {8'h00, out_r, out_g, out_b}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // Default table plus first out-of-range entry.
        for (int i = 0; i <= 11; i++) send(8'(i), 1'b0);
        drain();

        // Two-cycle latency on an empty pipe.
        send(8'd7, 1'b0);
        in_valid = 1'b0;
        check("latency_early", {31'd0, out_valid}, 32'd0);
        tick();
        check("latency_ontime", {31'd0, out_valid}, 32'd1);
        drain();

        // Write racing the lookup of the same entry sees the old colour.
        send(8'd3, 1'b0);
        in_valid = 1'b0;
        pal_write(4'd3, 24'h123456);
        send(8'd3, 1'b0);
        drain();
        pal_write(4'd3, 24'hFF9D00);
        drain();

        // Stall with stream 1,2,3.
        out_ready = 1'b0;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        in_valid = 1'b1;
        in_index = 8'd3;
        in_blank = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_rgb", {8'h00, out_r, out_g, out_b}, 32'h0003FBFF);
            tick();
        end
        out_ready = 1'b1;
        send(8'd3, 1'b0);
        drain();

        // Blanking and out-of-range indices.
        send(8'd10, 1'b1);
        send(8'd255, 1'b0);
        send(8'd16, 1'b0);
        send(8'd10, 1'b0);
        drain();

        // Reset mid-stream restores defaults and drops in-flight pixels.
        pal_write(4'd0, 24'h55AA33);
        send(8'd0, 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        Reset_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_rgb", {8'h00, out_r, out_g, out_b}, 32'd0);
        exp_q.delete();
        ref_reset();
        in_valid = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        send(8'd0, 1'b0);
        drain();

`ifdef PALETTE_READBACK_EN
        pal_write(4'd5, 24'hABCDEF);
        pal_re   = 1'b1;
        pal_addr = 4'd5;
        tick();
        pal_re   = 1'b0;
        check("readback", {8'h00, pal_rdata}, 32'h00ABCDEF);
        tick();
        check("readback_hold", {8'h00, pal_rdata}, 32'h00ABCDEF);
        pal_re = 1'b1;
        pal_write(4'd5, 24'h111111);
        check("readback_old", {8'h00, pal_rdata}, 32'h00ABCDEF);
        tick();
        pal_re = 1'b0;
        check("readback_new", {8'h00, pal_rdata}, 32'h00111111);
        drain();
`endif

        // Randomised rounds: palette updates between bursts of traffic.
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 3; w++) pal_write(4'($urandom_range(0, 15)), 24'($urandom));
            rand_ready_en = 1'b1;
            for (int p = 0; p < 60; p++) begin
                if (($urandom % 4) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
                send((($urandom % 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17)),
                     1'(($urandom % 8) == 0));
            end
            drain();
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
